hamming_encoder: RTL and testbench

HAMMING_ENCODER -- requirements
Module: hamming_encoder

---
 rtl/define.sv | 12 +
 rtl/hamming_encoder.sv | 111 +++++++++++
 tb/tb_hamming_encoder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/define.sv
// Shared widths and types for the Hamming(15,11) encoder.
`ifndef HAMMING_DEFINE_SV
`define HAMMING_DEFINE_SV

`define DATA_WIDTH    11
`define PARITY_WIDTH  4
`define PATTERN_WIDTH 15

typedef logic [`PARITY_WIDTH-1:0]  parity_t;
typedef logic [`PATTERN_WIDTH-1:0] pattern_t;

`endif

// File: rtl/hamming_encoder.sv
// Two-stage valid/ready Hamming(15,11) encoder with an accepted-word counter.
// Optional error injection on o_codeword is enabled by defining HAMMING_ERR_INJ_EN.
`include "define.sv"

module hamming_encoder #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [`DATA_WIDTH-1:0] i_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output pattern_t               o_codeword,
  output parity_t                o_parity,
  output logic [COUNT_WIDTH-1:0] o_count
`ifdef HAMMING_ERR_INJ_EN
  ,
  input  pattern_t               i_inj_mask
`endif
);

  // Handshake: a word moves on a rising edge when its valid and the receiver's
  // ready are both high; producers hold valid and data stable until accepted.

  // Codeword index i holds Hamming position i+1; parity k covers positions with bit k set.
  localparam pattern_t P0_MASK = 15'h5555;
  localparam pattern_t P1_MASK = 15'h6666;
  localparam pattern_t P2_MASK = 15'h7878;
  localparam pattern_t P3_MASK = 15'h7F80;

  logic                   s1_valid_q, s1_valid_d;
  logic [`DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                   s2_valid_q, s2_valid_d;
  pattern_t               cw_q, cw_d;
  parity_t                par_q, par_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
`ifdef HAMMING_ERR_INJ_EN
  pattern_t               s1_mask_q, s1_mask_d;
`endif

  logic     s2_adv, s1_adv, in_fire;
  pattern_t data_cw, enc_cw;
  parity_t  enc_par;

  assign s2_adv  = ~s2_valid_q | i_ready;
  assign s1_adv  = s1_valid_q & s2_adv;
  assign o_ready = ~i_rst & (~s1_valid_q | s2_adv);
  assign in_fire = i_valid & o_ready;

  always_comb begin
    data_cw        = '0;
    data_cw[2]     = s1_data_q[0];
    data_cw[6:4]   = s1_data_q[3:1];
    data_cw[14:8]  = s1_data_q[10:4];
    enc_par[0]     = ^(data_cw & P0_MASK);
    enc_par[1]     = ^(data_cw & P1_MASK);
    enc_par[2]     = ^(data_cw & P2_MASK);
    enc_par[3]     = ^(data_cw & P3_MASK);
    enc_cw         = data_cw;
    enc_cw[0]      = enc_par[0];
    enc_cw[1]      = enc_par[1];
    enc_cw[3]      = enc_par[2];
    enc_cw[7]      = enc_par[3];
  end

  always_comb begin
    s1_valid_d = in_fire | (s1_valid_q & ~s1_adv);
    s1_data_d  = in_fire ? i_data : s1_data_q;
    count_d    = in_fire ? count_q + COUNT_WIDTH'(1) : count_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    par_d      = s1_adv ? enc_par : par_q;
`ifdef HAMMING_ERR_INJ_EN
    s1_mask_d  = in_fire ? i_inj_mask : s1_mask_q;
    cw_d       = s1_adv ? (enc_cw ^ s1_mask_q) : cw_q;
`else
    cw_d       = s1_adv ? enc_cw : cw_q;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      cw_q       <= '0;
      par_q      <= '0;
      count_q    <= '0;
`ifdef HAMMING_ERR_INJ_EN
      s1_mask_q  <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      cw_q       <= cw_d;
      par_q      <= par_d;
      count_q    <= count_d;
`ifdef HAMMING_ERR_INJ_EN
      s1_mask_q  <= s1_mask_d;
`endif
    end
  end

  assign o_valid    = s2_valid_q;
  assign o_codeword = cw_q;
  assign o_parity   = par_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_hamming_encoder.sv
// Directed bench for hamming_encoder: encode vectors, latency, backpressure,
// streaming, reset flush and counter wrap (COUNT_WIDTH=4).
module tb_hamming_encoder;

  logic        clk = 1'b0;
  logic        rst, valid, rdy;
  logic [10:0] data;
  logic        o_ready, o_valid;
  logic [14:0] o_codeword;
  logic [3:0]  o_parity;
  logic [3:0]  o_count;
`ifdef HAMMING_ERR_INJ_EN
  logic [14:0] inj_mask;
  logic        inj_active;
`endif

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_out = 0;
  logic [10:0] exp_q[$];
  logic [3:0]  cnt_model = 4'd0;
  logic        last_acc;

  logic [10:0] tv_d  [6] = '{11'h000, 11'h001, 11'h002, 11'h010, 11'h400, 11'h7FF};
  logic [14:0] tv_cw [6] = '{15'h0000, 15'h0007, 15'h0019, 15'h0181, 15'h408B, 15'h7FFF};
  logic [3:0]  tv_par[6] = '{4'h0, 4'h3, 4'h5, 4'h9, 4'hF, 4'hF};
  logic [10:0] bp_d  [5] = '{11'h001, 11'h002, 11'h010, 11'h400, 11'h7FF};

  hamming_encoder #(.COUNT_WIDTH(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (valid),
    .o_ready    (o_ready),
    .i_data     (data),
    .o_valid    (o_valid),
    .i_ready    (rdy),
    .o_codeword (o_codeword),
    .o_parity   (o_parity),
    .o_count    (o_count)
`ifdef HAMMING_ERR_INJ_EN
    ,
    .i_inj_mask (inj_mask)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] syndrome(input logic [14:0] cw);
    logic [3:0] s = 4'd0;
    for (int p = 1; p <= 15; p++) if (cw[p-1]) s ^= 4'(p);
    return s;
  endfunction

  function automatic logic [10:0] extract(input logic [14:0] cw);
    logic [10:0] d = '0;
    int j = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = cw[p-1];
        j++;
      end
    end
    return d;
  endfunction

  // Drive one cycle, score both handshakes just before the edge, return after it.
  task automatic step(input logic v, input logic [10:0] d, input logic r, input logic rs);
    logic [10:0] e;
    valid = v; data = d; rdy = r; rst = rs;
    #1;
    last_acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      cnt_model = 4'd0;
    end else begin
      if (o_valid && rdy) begin
        check("out_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
`ifdef HAMMING_ERR_INJ_EN
          if (!inj_active) begin
            check("out_data", 32'(extract(o_codeword)), 32'(e));
            check("out_syndrome", 32'(syndrome(o_codeword)), 32'd0);
          end
`else
          check("out_data", 32'(extract(o_codeword)), 32'(e));
          check("out_syndrome", 32'(syndrome(o_codeword)), 32'd0);
`endif
        end
        n_out++;
      end
      if (valid && o_ready) begin
        exp_q.push_back(d);
        cnt_model++;
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int out_base;
    valid = 1'b0; data = '0; rdy = 1'b1; rst = 1'b1;
`ifdef HAMMING_ERR_INJ_EN
    inj_mask = '0;
    inj_active = 1'b0;
`endif

    // Reset state
    step(1'b0, 11'h0, 1'b1, 1'b1);
    step(1'b1, 11'h123, 1'b1, 1'b1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_codeword", 32'(o_codeword), 32'd0);
    check("rst_parity", 32'(o_parity), 32'd0);
    check("rst_ready_low", 32'(o_ready), 32'd0);
    rst = 1'b0; valid = 1'b0;
    #1;
    check("ready_after_release", 32'(o_ready), 32'd1);

    // Latency: 11'h001 -> 15'h0007, parity 4'h3, valid two cycles after accept
    step(1'b1, 11'h001, 1'b1, 1'b0);
    check("lat_accept", 32'(last_acc), 32'd1);
    check("lat_not_yet", 32'(o_valid), 32'd0);
    step(1'b0, 11'h0, 1'b1, 1'b0);
    check("lat_valid", 32'(o_valid), 32'd1);
    check("lat_codeword", 32'(o_codeword), 32'h0007);
    check("lat_parity", 32'(o_parity), 32'h3);
    step(1'b0, 11'h0, 1'b1, 1'b0);

    // Hand-computed encode vectors
    for (int i = 0; i < 6; i++) begin
      step(1'b1, tv_d[i], 1'b1, 1'b0);
      step(1'b0, 11'h0, 1'b1, 1'b0);
      check($sformatf("vec%0d_codeword", i), 32'(o_codeword), 32'(tv_cw[i]));
      check($sformatf("vec%0d_parity", i), 32'(o_parity), 32'(tv_par[i]));
      step(1'b0, 11'h0, 1'b1, 1'b0);
    end
    check("vec_count", 32'(o_count), 32'(cnt_model));

    // Backpressure: i_ready low for 5 cycles with continuous i_valid
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, bp_d[idx], 1'b0, 1'b0);
      if (last_acc) idx++;
      if (k >= 1) begin
        check("bp_ready_low", 32'(o_ready), 32'd0);
        check("bp_valid_hold", 32'(o_valid), 32'd1);
        check("bp_codeword_hold", 32'(o_codeword), 32'h0007);
        check("bp_parity_hold", 32'(o_parity), 32'h3);
      end
    end
    check("bp_accepted", 32'(idx), 32'd2);
    for (int k = 0; k < 10 && idx < 5; k++) begin
      step(1'b1, bp_d[idx], 1'b1, 1'b0);
      if (last_acc) idx++;
    end
    for (int k = 0; k < 3; k++) step(1'b0, 11'h0, 1'b1, 1'b0);
    check("bp_all_accepted", 32'(idx), 32'd5);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_count", 32'(o_count), 32'(cnt_model));

    // Streaming: 1000 random words at full rate
    out_base = n_out;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 11'($urandom_range(0, 2047)), 1'b1, 1'b0);
      check("stream_accept", 32'(last_acc), 32'd1);
      if (i >= 1) check("stream_valid", 32'(o_valid), 32'd1);
    end
    step(1'b0, 11'h0, 1'b1, 1'b0);
    step(1'b0, 11'h0, 1'b1, 1'b0);
    step(1'b0, 11'h0, 1'b1, 1'b0);
    check("stream_outputs", 32'(n_out - out_base), 32'd1000);
    check("stream_count", 32'(o_count), 32'(cnt_model));

    // Reset with both stages full
    step(1'b1, 11'h001, 1'b0, 1'b0);
    step(1'b1, 11'h002, 1'b0, 1'b0);
    check("full_ready_low", 32'(o_ready), 32'd0);
    step(1'b1, 11'h010, 1'b0, 1'b1);
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_count", 32'(o_count), 32'd0);
    check("flush_ready", 32'(o_ready), 32'd0);
    rst = 1'b0; valid = 1'b0;
    #1;
    check("flush_ready_release", 32'(o_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 11'h0, 1'b1, 1'b0);
      check("flush_no_stale", 32'(o_valid), 32'd0);
    end

    // Counter wrap: 17 accepts on a 4-bit counter
    for (int i = 0; i < 17; i++) step(1'b1, 11'($urandom_range(0, 2047)), 1'b1, 1'b0);
    check("wrap_count", 32'(o_count), 32'd1);
    for (int k = 0; k < 3; k++) step(1'b0, 11'h0, 1'b1, 1'b0);
    check("wrap_drained", 32'(exp_q.size()), 32'd0);

`ifdef HAMMING_ERR_INJ_EN
    // Injection: mask flips codeword bit 4, parity stays clean
    inj_mask = 15'h0010;
    step(1'b1, 11'h001, 1'b1, 1'b0);
    inj_mask = 15'h0000;
    inj_active = 1'b1;
    step(1'b0, 11'h0, 1'b1, 1'b0);
    check("inj_codeword", 32'(o_codeword), 32'h0017);
    check("inj_parity", 32'(o_parity), 32'h3);
    step(1'b0, 11'h0, 1'b1, 1'b0);
    inj_active = 1'b0;
`endif

    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
